// File: rtl/fdiv_sched.sv
// fdiv_sched: in-order tagged scheduler around a fixed-latency single-precision divider.
// Define FDIV_DIVZERO_FLAG_EN to carry a divide-by-zero flag alongside each result.

module fdiv #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);

  // Round-to-nearest-even quotient; subnormal inputs read as zero, tiny results flush to signed zero.
  function automatic logic [31:0] div_f(input logic [31:0] a, input logic [31:0] b);
    logic               sgn;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [49:0]        num;
    logic [49:0]        den;
    logic [26:0]        q;
    logic               rem_nz;
    logic [23:0]        mant;
    logic               g;
    logic               st;
    logic signed [10:0] e;
    logic [24:0]        rnd;
    logic [22:0]        frac;
    logic [31:0]        res;
    sgn    = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    num    = {1'b1, a[22:0], 26'd0};
    den    = {26'd0, 1'b1, b[22:0]};
    q      = 27'(num / den);
    rem_nz = ((num % den) != 50'd0);
    e      = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 11'sd127;
    if (q[26]) begin
      mant = q[26:3];
      g    = q[2];
      st   = (q[1:0] != 2'd0) | rem_nz;
    end else begin
      mant = q[25:2];
      g    = q[1];
      st   = q[0] | rem_nz;
      e    = e - 11'sd1;
    end
    rnd = {1'b0, mant} + {24'd0, g & (st | mant[0])};
    if (rnd[24]) begin
      e    = e + 11'sd1;
      frac = 23'd0;
    end else begin
      frac = rnd[22:0] | {22'd0, 1'b0 & rnd[23]};
    end
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) res = 32'h7FC0_0000;
    else if (a_inf | b_zero)                                  res = {sgn, 8'hFF, 23'd0};
    else if (a_zero | b_inf)                                  res = {sgn, 31'd0};
    else if (e >= 11'sd255)                                   res = {sgn, 8'hFF, 23'd0};
    else if (e <= 11'sd0)                                     res = {sgn, 31'd0};
    else                                                      res = {sgn, e[7:0], frac};
    return res;
  endfunction

  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] q_s;

  // Operand capture every cycle; the core never stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_r <= 32'd0;
      b_r <= 32'd0;
    end else begin
      a_r <= x1;
      b_r <= x2;
    end
  end

  assign q_s = div_f(a_r, b_r);

  generate
    if (LAT == 1) begin : g_comb
      assign y = q_s;
    end else begin : g_pipe
      logic [31:0] pipe [LAT-1];
      // Result pipeline filling out the remaining latency.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < LAT - 1; i++) pipe[i] <= 32'd0;
        end else begin
          pipe[0] <= q_s;
          for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign y = pipe[LAT-2];
    end
  endgenerate

endmodule

module fdiv_sched #(
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     x1,
  input  logic [31:0]     x2,
  input  logic [TAGW-1:0] req_tag,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     y,
  output logic [TAGW-1:0] resp_tag,
  output logic            resp_dz
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return {PW{1'b0}};
    else                     return p + PW'(1);
  endfunction

  logic [31:0]     core_y;
  logic [LAT-1:0]  vld;
  logic [TAGW-1:0] tag_pipe [LAT];
  logic [CW-1:0]   occ;
  logic [CW-1:0]   occ_next;
  logic            ready_r;
  logic [31:0]     mem_y   [DEPTH];
  logic [TAGW-1:0] mem_tag [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            valid_r;
  logic            acc_s;
  logic            pop_s;
  logic            wr_s;

  fdiv #(.LAT(LAT)) u_fdiv (
    .clk  (clk),
    .rstn (rstn),
    .x1   (x1),
    .x2   (x2),
    .y    (core_y)
  );

  assign acc_s = req_valid & ready_r;
  assign pop_s = valid_r & resp_ready;
  assign wr_s  = vld[LAT-1];

  // Occupancy covers in-flight plus buffered results, so the FIFO can never overflow.
  always_comb begin
    occ_next = occ;
    case ({acc_s, pop_s})
      2'b10:   occ_next = occ + ONE_C;
      2'b01:   occ_next = occ - ONE_C;
      default: occ_next = occ;
    endcase
  end

  // Registered occupancy and admission flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ     <= {CW{1'b0}};
      ready_r <= 1'b1;
    end else begin
      occ     <= occ_next;
      ready_r <= (occ_next < DEPTH_C);
    end
  end

  // Valid/tag tracking aligned with the core pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= {TAGW{1'b0}};
    end else begin
      vld[0]      <= acc_s;
      tag_pipe[0] <= req_tag;
      for (int i = 1; i < LAT; i++) begin
        vld[i]      <= vld[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Entry count for the empty flag.
  always_comb begin
    cnt_next = cnt;
    case ({wr_s, pop_s})
      2'b10:   cnt_next = cnt + ONE_C;
      2'b01:   cnt_next = cnt - ONE_C;
      default: cnt_next = cnt;
    endcase
  end

  // Circular-buffer pointers and registered non-empty flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= {PW{1'b0}};
      rd_ptr  <= {PW{1'b0}};
      cnt     <= {CW{1'b0}};
      valid_r <= 1'b0;
    end else begin
      if (wr_s)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop_s) rd_ptr <= ptr_inc(rd_ptr);
      cnt     <= cnt_next;
      valid_r <= (cnt_next != {CW{1'b0}});
    end
  end

  // Result storage; contents are only visible while the entry is valid.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_y[wr_ptr]   <= core_y;
      mem_tag[wr_ptr] <= tag_pipe[LAT-1];
    end
  end

  assign req_ready  = ready_r;
  assign resp_valid = valid_r;
  assign y          = valid_r ? mem_y[rd_ptr]   : 32'd0;
  assign resp_tag   = valid_r ? mem_tag[rd_ptr] : {TAGW{1'b0}};

`ifdef FDIV_DIVZERO_FLAG_EN
  logic [LAT-1:0] dz_pipe;
  logic           mem_dz [DEPTH];

  // Divide-by-zero flag travels with the tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dz_pipe <= {LAT{1'b0}};
    end else begin
      dz_pipe[0] <= (x2[30:23] == 8'd0);
      for (int i = 1; i < LAT; i++) dz_pipe[i] <= dz_pipe[i-1];
    end
  end

  // Flag storage alongside the result entry.
  always_ff @(posedge clk) begin
    if (wr_s) mem_dz[wr_ptr] <= dz_pipe[LAT-1];
  end

  assign resp_dz = valid_r & mem_dz[rd_ptr];
`else
  assign resp_dz = 1'b0;
`endif

endmodule

// File: tb/tb_fdiv_sched.sv
// Scoreboard bench for fdiv_sched: real-arithmetic reference divider, queued expectations, decoupled monitor.
module tb_fdiv_sched;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] y;
  logic [4:0]  resp_tag;
  logic        resp_dz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_push = 0;
  int n_pop = 0;
  int n_drop = 0;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        dz;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  logic        held = 1'b0;
  logic [31:0] held_y;
  logic [4:0]  held_tag;

  fdiv_sched #(.LAT(LAT), .DEPTH(8), .TAGW(5)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .x1         (x1),
    .x2         (x2),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .y          (y),
    .resp_tag   (resp_tag),
    .resp_dz    (resp_dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real to_real(input logic [31:0] v);
    logic [63:0] d;
    d = {1'b0, 11'(int'(v[30:23]) + 896), v[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Reference: exact-enough double quotient rounded once more to 24 bits (double rounding is innocuous here).
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e_unb, es;
    logic        s, a_nan, b_nan, a_inf, b_inf;
    real         q;
    logic [63:0] qb;
    logic [24:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 23'd0);
    b_nan = (eb == 255) && (b[22:0] != 23'd0);
    a_inf = (ea == 255) && (a[22:0] == 23'd0);
    b_inf = (eb == 255) && (b[22:0] == 23'd0);
    if (a_nan || b_nan || (ea == 0 && eb == 0) || (a_inf && b_inf)) return 32'h7FC0_0000;
    if (a_inf || eb == 0) return {s, 8'hFF, 23'd0};
    if (ea == 0 || b_inf) return {s, 31'd0};
    q  = to_real(a) / to_real(b);
    qb = $realtobits(q);
    e_unb = int'(qb[62:52]) - 1023;
    m  = {2'b01, qb[51:29]};
    if (qb[28] && ((qb[27:0] != 28'd0) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      e_unb = e_unb + 1;
      m = m >> 1;
    end
    es = e_unb + 127;
    if (es >= 255) return {s, 8'hFF, 23'd0};
    if (es <= 0)   return {s, 31'd0};
    return {s, 8'(es), m[22:0]};
  endfunction

  function automatic logic ref_dz(input logic [31:0] b);
`ifdef FDIV_DIVZERO_FLAG_EN
    return (b[30:23] == 8'd0);
`else
    return 1'b0 & b[0];
`endif
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    logic [31:0] r;
    k = $urandom_range(0, 9);
    r = $urandom;
    case (k)
      0: return r;
      1: begin
        case ($urandom_range(0, 8))
          0: return 32'h0000_0000;
          1: return 32'h8000_0000;
          2: return 32'h7F80_0000;
          3: return 32'hFF80_0000;
          4: return 32'h7FC0_0000;
          5: return 32'h0000_0001;
          6: return 32'h3F80_0000;
          7: return 32'h7F7F_FFFF;
          default: return 32'h0080_0000;
        endcase
      end
      2: return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
      default: return {r[31], 8'($urandom_range(110, 144)), r[22:0]};
    endcase
  endfunction

  // Monitor: record accepted requests, compare every popped response in order.
  always @(negedge clk) begin
    if (!rstn) begin
      n_drop = n_drop + exp_q.size();
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!resp_valid || y !== held_y || resp_tag !== held_tag) begin
          errors++;
          $display("FAIL hold: got v=%b y=%h tag=%0d, expected v=1 y=%h tag=%0d",
                   resp_valid, y, resp_tag, held_y, held_tag);
        end
      end
      held = 1'b0;
      if (resp_valid && resp_ready) begin
        checks++;
        n_pop++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious: got y=%h tag=%0d, expected no response", y, resp_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (y !== e.y || resp_tag !== e.tag || resp_dz !== e.dz || cyc < e.acc + LAT) begin
            errors++;
            $display("FAIL resp: got y=%h tag=%0d dz=%b at cyc %0d, expected y=%h tag=%0d dz=%b not before cyc %0d",
                     y, resp_tag, resp_dz, cyc, e.y, e.tag, e.dz, e.acc + LAT);
          end
        end
      end else if (resp_valid) begin
        held = 1'b1;
        held_y = y;
        held_tag = resp_tag;
      end
      if (req_valid && req_ready) begin
        exp_t n;
        n.y = ref_div(x1, x2);
        n.tag = req_tag;
        n.dz = ref_dz(x2);
        n.acc = cyc + 1;
        exp_q.push_back(n);
        n_push++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Back-to-back requests; starts and ends just after a rising edge.
  task automatic burst(input int n, input int tag0);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b1;
      x1 = rand_op();
      x2 = rand_op();
      req_tag = 5'(tag0 + i);
      @(negedge clk);
      chk("burst_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t, output int acc_edge);
    req_valid = 1'b1;
    x1 = a;
    x2 = b;
    req_tag = t;
    acc_edge = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1;
    acc_edge = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int seen);
    seen = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got no resp_valid within 30 cycles, expected one");
    end
  endtask

  task automatic drain();
    bit done = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !resp_valid) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got %0d entries pending, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen, sent, guard;
    bit took;
    rstn = 1'b0;
    req_valid = 1'b0;
    x1 = 32'd0;
    x2 = 32'd0;
    req_tag = 5'd0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_tag_dz", {26'd0, resp_tag, resp_dz}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic quotient and latency: 6/2 = 3.
    send(32'h40C0_0000, 32'h4000_0000, 5'd3, n);
    wait_valid(seen);
    chk("lat_first_valid", 32'(seen), 32'(n + LAT));
    chk("basic_y", y, 32'h4040_0000);
    chk("basic_tag", {27'd0, resp_tag}, 32'd3);
    @(posedge clk); #1;
    drain();

    // Divide by zero: infinity, flag depends on build.
    send(32'h3F80_0000, 32'h0000_0000, 5'd4, n);
    wait_valid(seen);
    chk("dz_y", y, 32'h7F80_0000);
`ifdef FDIV_DIVZERO_FLAG_EN
    chk("dz_flag", {31'd0, resp_dz}, 32'd1);
`else
    chk("dz_flag", {31'd0, resp_dz}, 32'd0);
`endif
    @(posedge clk); #1;
    drain();

    // Fill with responses stalled, then release in order.
    resp_ready = 1'b0;
    burst(8, 0);
    @(negedge clk);
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    repeat (LAT + 2) @(negedge clk);
    chk("full_head", {26'd0, resp_valid, resp_tag}, {26'd0, 1'b1, 5'd0});
    chk("full_occ", 32'(dut.occ), 32'd8);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("inorder_tag", {26'd0, resp_valid, resp_tag}, {26'd0, 1'b1, 5'(i)});
    end
    @(negedge clk);
    chk("empty_after", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    drain();

    // Pop at full with a pending request: no acceptance, ready next cycle.
    resp_ready = 1'b0;
    burst(8, 8);
    repeat (LAT + 2) @(posedge clk);
    #1;
    req_valid = 1'b1;
    x1 = 32'h3F80_0000;
    x2 = 32'h3F80_0000;
    req_tag = 5'd31;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("pop_full_ready", {30'd0, req_ready, resp_valid}, {30'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("pop_full_next", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    drain();

    // Reset mid-flight discards everything.
    resp_ready = 1'b0;
    burst(3, 20);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_out", {30'd0, req_ready, resp_valid}, {30'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    rstn = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("postrst", {30'd0, req_ready, resp_valid}, {30'd0, 1'b1, 1'b0});
    end
    chk("postrst_occ", 32'(dut.occ), 32'd0);
    @(posedge clk); #1;

    // Long random run with random backpressure.
    sent = 0;
    guard = 0;
    req_valid = 1'b1;
    x1 = rand_op();
    x2 = rand_op();
    req_tag = 5'd0;
    while (sent < 1000 && guard < 20000) begin
      @(negedge clk);
      took = req_ready;
      @(posedge clk); #1;
      resp_ready = ($urandom_range(0, 1) == 1);
      if (took) begin
        sent++;
        x1 = rand_op();
        x2 = rand_op();
        req_tag = 5'(sent);
      end
      guard++;
    end
    req_valid = 1'b0;
    chk("random_sent", 32'(sent), 32'd1000);
    drain();
    chk("no_loss", 32'(n_pop + n_drop), 32'(n_push));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
